// File: rtl/fs_inst_queue_pkg.sv
// Shared widths and packet layout for the fetch-to-decode instruction queue.
package fs_inst_queue_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int FQ_DEPTH        = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_pkt_t;

endpackage

// File: rtl/fs_inst_queue.sv
// Flop-based circular buffer between fetch and decode using valid/allowin handshakes.
// Latency 1 cycle (no bypass); a full queue refuses input; flush empties the queue in one cycle.
module fs_inst_queue
    import fs_inst_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WD    = FS_TO_DS_BUS_WD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   fs_to_fq_valid,
    input  logic [WD-1:0]          fs_to_fq_bus,
    output logic                   fq_allowin,
    output logic                   fq_to_ds_valid,
    output logic [WD-1:0]          fq_to_ds_bus,
    input  logic                   ds_allowin,
    output logic [$clog2(DEPTH):0] fq_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WD-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    // allowin looks only at occupancy so it never forms a path from decode back to fetch
    assign fq_allowin     = (count_q != CW'(DEPTH));
    assign fq_to_ds_valid = (count_q != '0) && !flush;
    assign fq_to_ds_bus   = mem_q[rd_ptr_q];
    assign fq_count       = count_q;

    assign push = fs_to_fq_valid && fq_allowin && !flush;
    assign pop  = fq_to_ds_valid && ds_allowin;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries reset to zero so the bus reads 0 out of reset; flush leaves them alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= fs_to_fq_bus;
        end
    end

endmodule

// File: tb/tb_fs_inst_queue.sv
// Scoreboard bench: accepted packets are queued, and each decode pop is compared against the queue head.
module tb_fs_inst_queue;
    import fs_inst_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int WD    = 64;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          fs_to_fq_valid;
    logic [WD-1:0] fs_to_fq_bus;
    logic          fq_allowin;
    logic          fq_to_ds_valid;
    logic [WD-1:0] fq_to_ds_bus;
    logic          ds_allowin;
    logic [2:0]    fq_count;

    int vectors;
    int miscompares;
    logic [WD-1:0] sb[$];

    fs_inst_queue #(.DEPTH(DEPTH), .WD(WD)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .fs_to_fq_valid (fs_to_fq_valid),
        .fs_to_fq_bus   (fs_to_fq_bus),
        .fq_allowin     (fq_allowin),
        .fq_to_ds_valid (fq_to_ds_valid),
        .fq_to_ds_bus   (fq_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .fq_count       (fq_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [WD-1:0] mk(input logic [31:0] pc);
        fq_pkt_t p;
        p.pc   = pc;
        p.inst = pc ^ 32'hA5A5_3C3C;
        return p;
    endfunction

    // Drive one cycle's inputs just after the falling edge
    task automatic cyc(input logic v, input logic [31:0] pc, input logic da, input logic fl);
        @(negedge clk);
        fs_to_fq_valid = v;
        fs_to_fq_bus   = mk(pc);
        ds_allowin     = da;
        flush          = fl;
    endtask

    // Monitor: compare pops against the scoreboard, then record accepted pushes
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (fq_to_ds_valid && ds_allowin) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_unexpected: got %h, scoreboard empty", fq_to_ds_bus);
                end else begin
                    logic [WD-1:0] exp;
                    exp = sb.pop_front();
                    if (fq_to_ds_bus !== exp) begin
                        miscompares++;
                        $display("FAIL pop_data: got %h, expected %h", fq_to_ds_bus, exp);
                    end
                end
            end
            if (flush) sb.delete();
            else if (fs_to_fq_valid && fq_allowin) sb.push_back(fs_to_fq_bus);
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        flush = 1'b0;
        fs_to_fq_valid = 1'b0;
        fs_to_fq_bus = '0;
        ds_allowin = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({fq_allowin, fq_to_ds_valid, fq_count} !== {1'b1, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_ctrl: allowin/valid/count got %b/%b/%0d, expected 1/0/0",
                     fq_allowin, fq_to_ds_valid, fq_count);
        end
        vectors++;
        if (fq_to_ds_bus !== '0) begin
            miscompares++;
            $display("FAIL reset_bus: got %h, expected 0", fq_to_ds_bus);
        end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h1c00_0000 + 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b1, 32'h1c00_0010, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fq_count !== 3'd4 || fq_allowin !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: count/allowin got %0d/%b, expected 4/0", fq_count, fq_allowin);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fq_count !== 3'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL fill_drain: count got %0d, expected 0; %0d packets not seen", fq_count, sb.size());
        end
    endtask

    task automatic test_stream;
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'h1c00_1000 + 32'(i * 4), 1'b1, 1'b0);
            #1;
            if (i > 0 && (fq_count !== 3'd1 || fq_to_ds_valid !== 1'b1)) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stream_steady: %0d cycles without count=1/valid=1, expected 0", bad);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (fq_count !== 3'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL stream_drain: count got %0d, expected 0; %0d packets not seen", fq_count, sb.size());
        end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h1c00_2000 + 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b1, 32'h1c00_2010, 1'b1, 1'b0);
        #1;
        vectors++;
        if (fq_allowin !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_refuse: allowin got %b, expected 0", fq_allowin);
        end
        cyc(1'b1, 32'h1c00_2010, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fq_count !== 3'd3 || fq_allowin !== 1'b1) begin
            miscompares++;
            $display("FAIL full_pop_count: count/allowin got %0d/%b, expected 3/1", fq_count, fq_allowin);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fq_count !== 3'd4) begin
            miscompares++;
            $display("FAIL full_pop_accept: count got %0d, expected 4", fq_count);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fq_count !== 3'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL full_pop_drain: count got %0d, expected 0; %0d packets not seen", fq_count, sb.size());
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h1c00_3000 + 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b1, 32'h1c00_0100, 1'b1, 1'b1);
        #1;
        vectors++;
        if (fq_to_ds_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_mask: valid got %b, expected 0", fq_to_ds_valid);
        end
        cyc(1'b1, 32'h1c00_0200, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fq_count !== 3'd0 || fq_allowin !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_empty: count/allowin got %0d/%b, expected 0/1", fq_count, fq_allowin);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (fq_to_ds_valid !== 1'b1 || fq_to_ds_bus !== mk(32'h1c00_0200)) begin
            miscompares++;
            $display("FAIL flush_first: valid/bus got %b/%h, expected 1/%h",
                     fq_to_ds_valid, fq_to_ds_bus, mk(32'h1c00_0200));
        end
        // Flush from full must reopen allowin on the following cycle
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h1c00_4000 + 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fq_allowin !== 1'b1 || fq_count !== 3'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL flush_full: allowin/count got %b/%0d, expected 1/0; scoreboard %0d",
                     fq_allowin, fq_count, sb.size());
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 2; i++) cyc(1'b1, 32'h1c00_5000 + 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fq_count !== 3'd2 || fq_to_ds_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: count/valid got %0d/%b, expected 2/1", fq_count, fq_to_ds_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({fq_allowin, fq_to_ds_valid, fq_count} !== {1'b1, 1'b0, 3'd0} || fq_to_ds_bus !== '0) begin
            miscompares++;
            $display("FAIL areset_clear: allowin/valid/count/bus got %b/%b/%0d/%h, expected 1/0/0/0",
                     fq_allowin, fq_to_ds_valid, fq_count, fq_to_ds_bus);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 32'h1c00_6000, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fq_count !== 3'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL areset_resume: count got %0d, expected 0; %0d packets not seen", fq_count, sb.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        flush = 1'b0;
        fs_to_fq_valid = 1'b0;
        fs_to_fq_bus = '0;
        ds_allowin = 1'b0;
        test_reset();
        test_fill();
        test_stream();
        test_full_pop();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
